// File: rtl/sobol_rng_mc.sv
// Multi-channel Sobol sequence generator: shared index counter, LSZ search,
// and a run-time loadable direction-vector table per dimension.
module sobol_rng_mc #(
  parameter int BITWIDTH    = 8,
  parameter int LOGBITWIDTH = $clog2(BITWIDTH),
  parameter int DIMS        = 2,
  parameter int DIMW        = (DIMS > 1) ? $clog2(DIMS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iEn,
  input  logic                     iClr,
  input  logic                     iDvLoad,
  input  logic [DIMW-1:0]          iDvDim,
  input  logic [LOGBITWIDTH-1:0]   iDvIdx,
  input  logic [BITWIDTH-1:0]      iDvData,
  output logic [DIMS*BITWIDTH-1:0] oSobol,
  output logic                     oValid,
  output logic [LOGBITWIDTH-1:0]   oLszIdx,
  output logic                     oWrap
);

  logic [BITWIDTH-1:0]            cnt_q;
  logic [DIMS-1:0][BITWIDTH-1:0]  x_q, x_d;
  logic [BITWIDTH-1:0]            dv_q [DIMS][BITWIDTH];
  logic                           valid_q;
  logic [LOGBITWIDTH-1:0]         lsz_q, lsz_d;
  logic                           wrap_q;
  logic                           cnt_full;
  logic                           dv_wr_ok;

  // Scan from the top so the lowest zero bit wins; all-ones falls back to the MSB index.
  always_comb begin
    lsz_d = LOGBITWIDTH'(BITWIDTH - 1);
    for (int i = BITWIDTH - 1; i >= 0; i--) begin
      if (!cnt_q[i]) lsz_d = LOGBITWIDTH'(i);
    end
  end

  assign cnt_full = &cnt_q;

  always_comb begin
    x_d = x_q;
    for (int d = 0; d < DIMS; d++) begin
      x_d[d] = x_q[d] ^ dv_q[d][lsz_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
      lsz_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (iClr) begin
      cnt_q   <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
      lsz_q   <= '0;
      wrap_q  <= 1'b0;
    end else if (iEn) begin
      valid_q <= 1'b1;
      lsz_q   <= lsz_d;
      if (cnt_full) begin
        cnt_q  <= '0;
        x_q    <= '0;
        wrap_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + BITWIDTH'(1);
        x_q    <= x_d;
        wrap_q <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign dv_wr_ok = (32'(iDvDim) < 32'(DIMS)) && (32'(iDvIdx) < 32'(BITWIDTH));

  // Table reset is van der Corput; advances read the pre-edge value, so same-cycle writes land after use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < DIMS; d++) begin
        for (int k = 0; k < BITWIDTH; k++) begin
          dv_q[d][k] <= BITWIDTH'(1) << (BITWIDTH - 1 - k);
        end
      end
    end else if (iDvLoad && dv_wr_ok) begin
      dv_q[iDvDim][iDvIdx] <= iDvData;
    end
  end

  assign oSobol  = x_q;
  assign oValid  = valid_q;
  assign oLszIdx = lsz_q;
  assign oWrap   = wrap_q;

endmodule
